// File: rtl/ifu_fetch.sv
// Instruction-fetch front end: owns the fetch PC, issues in-order requests on an
// SRAM-like instruction port, squashes responses from redirected paths and
// buffers returned instructions for decode over a valid/allowin handshake.
module ifu_fetch #(
    parameter logic [31:0] RESET_PC  = 32'h8000_0000,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        br_e,
    input  logic [31:0] br_addr,
    output logic        inst_req,
    output logic [31:0] inst_addr,
    input  logic        inst_addr_ok,
    input  logic        inst_data_ok,
    input  logic [31:0] inst_rdata,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_inst,
    input  logic        id_allowin
);

    localparam int PW = $clog2(BUF_DEPTH);
    localparam int CW = PW + 1;

    logic          resetn_q;
    logic [31:0]   fetch_pc_q, fetch_pc_d;

    // In-flight request PCs, oldest at infl_rd_q
    logic [31:0]   infl_pc_q [BUF_DEPTH];
    logic [PW-1:0] infl_wr_q, infl_rd_q;
    logic [CW-1:0] inflight_q, inflight_d;
    logic [CW-1:0] cancel_q, cancel_d;

    // Instruction buffer, head at buf_rd_q
    logic [31:0]   buf_pc_q   [BUF_DEPTH];
    logic [31:0]   buf_inst_q [BUF_DEPTH];
    logic [PW-1:0] buf_wr_q, buf_rd_q;
    logic [CW-1:0] buf_cnt_q, buf_cnt_d;

    logic [CW:0]   occupancy;
    logic          credit_ok;
    logic          accept;
    logic          resp_cancel;
    logic          resp_live;
    logic          buf_push;
    logic          buf_pop;
    logic          buf_nonempty;

    // Outstanding requests plus buffered words never exceed the buffer size, so
    // every kept response is guaranteed a free slot.
    assign occupancy    = {1'b0, inflight_q} + {1'b0, buf_cnt_q};
    assign credit_ok    = occupancy < (CW+1)'(BUF_DEPTH);

    assign inst_req     = resetn_q & ~br_e & credit_ok;
    assign inst_addr    = {fetch_pc_q[31:2], 2'b00};
    assign accept       = inst_req & inst_addr_ok;

    assign resp_cancel  = inst_data_ok & (cancel_q != '0);
    assign resp_live    = inst_data_ok & (cancel_q == '0);
    assign buf_push     = resp_live & ~br_e;

    assign buf_nonempty = (buf_cnt_q != '0);
    assign if_valid     = buf_nonempty & ~br_e;
    assign buf_pop      = if_valid & id_allowin;
    assign if_pc        = buf_nonempty ? buf_pc_q[buf_rd_q]   : 32'h0;
    assign if_inst      = buf_nonempty ? buf_inst_q[buf_rd_q] : 32'h0;

    // Next-state arithmetic for PC and the three occupancy counters
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        if (br_e) begin
            fetch_pc_d = {br_addr[31:2], 2'b00};
        end else if (accept) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
        end

        // No request is accepted while br_e is high, so accept is 0 then.
        inflight_d = inflight_q + CW'(accept) - CW'(inst_data_ok);

        // On redirect every request still outstanding after this cycle belongs
        // to the old path: (cancel - cancelled resp) + (live - live resp)
        // collapses to inflight minus any response retired this cycle.
        if (br_e) begin
            cancel_d = inflight_q - CW'(inst_data_ok);
        end else begin
            cancel_d = cancel_q - CW'(resp_cancel);
        end

        if (br_e) begin
            buf_cnt_d = '0;
        end else begin
            buf_cnt_d = buf_cnt_q + CW'(buf_push) - CW'(buf_pop);
        end
    end

    // Control state: PC, pointers and counters, cleared by synchronous reset
    always_ff @(posedge clk) begin
        if (!resetn) begin
            resetn_q   <= 1'b0;
            fetch_pc_q <= RESET_PC;
            infl_wr_q  <= '0;
            infl_rd_q  <= '0;
            inflight_q <= '0;
            cancel_q   <= '0;
            buf_wr_q   <= '0;
            buf_rd_q   <= '0;
            buf_cnt_q  <= '0;
        end else begin
            resetn_q   <= 1'b1;
            fetch_pc_q <= fetch_pc_d;
            infl_wr_q  <= infl_wr_q + PW'(accept);
            infl_rd_q  <= infl_rd_q + PW'(inst_data_ok);
            inflight_q <= inflight_d;
            cancel_q   <= cancel_d;
            buf_cnt_q  <= buf_cnt_d;
            if (br_e) begin
                buf_wr_q <= '0;
                buf_rd_q <= '0;
            end else begin
                buf_wr_q <= buf_wr_q + PW'(buf_push);
                buf_rd_q <= buf_rd_q + PW'(buf_pop);
            end
        end
    end

    // Storage arrays: contents are only meaningful under the counters above
    always_ff @(posedge clk) begin
        if (accept) begin
            infl_pc_q[infl_wr_q] <= inst_addr;
        end
        if (buf_push) begin
            buf_pc_q[buf_wr_q]   <= infl_pc_q[infl_rd_q];
            buf_inst_q[buf_wr_q] <= inst_rdata;
        end
    end

endmodule

// File: tb/tb_ifu_fetch.sv
// Self-checking bench for ifu_fetch: directed scenarios followed by random
// traffic, compared every cycle against an epoch-tagged reference model.
module tb_ifu_fetch;

    localparam logic [31:0] RESET_PC = 32'h8000_0000;
    localparam int          DEPTH    = 2;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        br_e = 1'b0;
    logic [31:0] br_addr = 32'h0;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok = 1'b0;
    logic        inst_data_ok = 1'b0;
    logic [31:0] inst_rdata = 32'h0;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        id_allowin = 1'b0;

    ifu_fetch #(.RESET_PC(RESET_PC), .BUF_DEPTH(DEPTH)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .br_e         (br_e),
        .br_addr      (br_addr),
        .inst_req     (inst_req),
        .inst_addr    (inst_addr),
        .inst_addr_ok (inst_addr_ok),
        .inst_data_ok (inst_data_ok),
        .inst_rdata   (inst_rdata),
        .if_valid     (if_valid),
        .if_pc        (if_pc),
        .if_inst      (if_inst),
        .id_allowin   (id_allowin)
    );

    always #5 clk = ~clk;

    // Reference model: outstanding requests tagged with the path epoch they
    // were issued on; a redirect starts a new epoch, so anything tagged older
    // is dropped on return.
    typedef struct {
        logic [31:0] pc;
        int          epoch;
        int          ready;
    } req_t;
    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } ent_t;

    req_t        mq[$];
    ent_t        mbuf[$];
    logic [31:0] m_pc = RESET_PC;
    bit          m_rst_q = 1'b0;
    int          m_epoch = 0;
    int          cyc = 0;
    int          lat_min = 1;
    int          lat_max = 1;
    int          errors = 0;
    int          checks = 0;

    function automatic logic [31:0] memf(input logic [31:0] pc);
        return (pc * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h cycle=%0d", tag, obs, exp, cyc);
        end
    endtask

    // One clock cycle: drive inputs, compare outputs to the model, advance model
    task automatic step(input bit rn, input bit be, input logic [31:0] ba,
                        input bit aok, input bit allow);
        bit          exp_req, exp_valid, dok, accept;
        logic [31:0] exp_pc, exp_inst;
        int          stale;
        req_t        r;
        ent_t        e;
        @(posedge clk);
        #1;
        dok          = rn && (mq.size() > 0) && (mq[0].ready <= cyc);
        resetn       = rn;
        br_e         = be;
        br_addr      = ba;
        inst_addr_ok = aok;
        id_allowin   = allow;
        inst_data_ok = dok;
        inst_rdata   = dok ? memf(mq[0].pc) : $urandom;
        #3;
        exp_req   = m_rst_q && !be && ((mq.size() + mbuf.size()) < DEPTH);
        exp_valid = (mbuf.size() != 0) && !be;
        exp_pc    = (mbuf.size() != 0) ? mbuf[0].pc   : 32'h0;
        exp_inst  = (mbuf.size() != 0) ? mbuf[0].inst : 32'h0;
        stale = 0;
        foreach (mq[i]) if (mq[i].epoch != m_epoch) stale++;
        chk("inst_req", {31'h0, inst_req}, {31'h0, exp_req});
        if (exp_req) chk("inst_addr", inst_addr, m_pc);
        chk("if_valid", {31'h0, if_valid}, {31'h0, exp_valid});
        chk("if_pc", if_pc, exp_pc);
        chk("if_inst", if_inst, exp_inst);
        chk("cancel_cnt", 32'(dut.cancel_q), 32'(stale));
        if (exp_valid) $display("cyc %0d: if pc=%h inst=%h allow=%0d", cyc, exp_pc, exp_inst, allow);

        if (!rn) begin
            m_rst_q = 1'b0;
            m_pc    = RESET_PC;
            mq.delete();
            mbuf.delete();
        end else begin
            m_rst_q = 1'b1;
            accept  = exp_req && aok;
            if (exp_valid && allow) void'(mbuf.pop_front());
            if (dok) begin
                r = mq.pop_front();
                if (r.epoch == m_epoch && !be) begin
                    e.pc   = r.pc;
                    e.inst = memf(r.pc);
                    mbuf.push_back(e);
                end
            end
            if (be) begin
                mbuf.delete();
                m_epoch++;
                m_pc = {ba[31:2], 2'b00};
            end else if (accept) begin
                r.pc    = m_pc;
                r.epoch = m_epoch;
                r.ready = cyc + $urandom_range(lat_max, lat_min);
                mq.push_back(r);
                m_pc = m_pc + 32'd4;
            end
        end
        cyc++;
    endtask

    initial begin
        // Reset
        repeat (3) step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);

        // 1: streaming fetch with one-cycle memory
        lat_min = 1; lat_max = 1;
        repeat (10) step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);

        // 2: decode stalled, buffer fills, then drains
        repeat (8) step(1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
        repeat (6) step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);

        // 3: redirect with two slow requests outstanding
        lat_min = 3; lat_max = 3;
        repeat (3) step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
        step(1'b1, 1'b1, 32'h8000_1000, 1'b1, 1'b1);
        repeat (12) step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);

        // 4: redirect coinciding with a live response and a pending head
        lat_min = 1; lat_max = 1;
        repeat (6) step(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) begin
            if (mbuf.size() > 0 && mq.size() > 0 && mq[0].ready <= cyc && mq[0].epoch == m_epoch) begin
                step(1'b1, 1'b1, 32'h0000_4000, 1'b1, 1'b1);
                break;
            end
            step(1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
        end
        repeat (6) step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);

        // 5: back-to-back redirects, last target wins
        lat_min = 2; lat_max = 2;
        repeat (2) step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
        step(1'b1, 1'b1, 32'h0000_0100, 1'b1, 1'b1);
        step(1'b1, 1'b1, 32'h0000_0200, 1'b1, 1'b1);
        repeat (10) step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);

        // 6: PC wrap, then reset with requests in flight
        lat_min = 1; lat_max = 1;
        step(1'b1, 1'b1, 32'hFFFF_FFFC, 1'b1, 1'b1);
        repeat (6) step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
        lat_min = 4; lat_max = 4;
        repeat (3) step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
        repeat (2) step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        lat_min = 1; lat_max = 1;
        repeat (6) step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);

        // Random traffic
        lat_min = 1; lat_max = 4;
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(199, 0) != 0),
                 ($urandom_range(19, 0) == 0),
                 $urandom,
                 ($urandom_range(9, 0) < 7),
                 ($urandom_range(9, 0) < 7));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ifu_fetch.md
Name: ifu_fetch

Overview:
- Instruction-fetch front end that consumes the branch unit's redirect outputs (br_e, br_addr).
- Owns the fetch PC and issues sequential requests on an SRAM-like instruction-memory port (req/addr_ok, data_ok).
- Tracks in-flight requests and discards responses that belong to a squashed path.
- Buffers returned instructions and hands {pc, inst} to decode over a valid/allowin handshake.

Parameters:
- RESET_PC, 32'h8000_0000, fetch PC after reset.
- BUF_DEPTH, 2, instruction buffer entries; also the maximum number of outstanding requests (power of 2, 2..8).

Ports:
- clk  input  1  clock, all state updates on rising edge
- resetn  input  1  synchronous active-low reset
- br_e  input  1  redirect valid (taken branch/jump resolved)
- br_addr  input  32  redirect target
- inst_req  output  1  fetch request valid
- inst_addr  output  32  fetch address, {fetch_pc[31:2],2'b00}
- inst_addr_ok  input  1  request accepted this cycle (only meaningful with inst_req)
- inst_data_ok  input  1  one response returned this cycle, strictly in request order
- inst_rdata  input  32  response instruction word
- if_valid  output  1  {if_pc, if_inst} valid to decode
- if_pc  output  32  PC of head instruction
- if_inst  output  32  head instruction
- id_allowin  input  1  decode accepts head this cycle

Behaviour:
- Reset (resetn=0 at an edge):
  - fetch_pc=RESET_PC; buffer, in-flight queue and cancel_cnt cleared.
  - Outputs after reset: inst_req=0 for that cycle, if_valid=0, if_pc=0, if_inst=0.
  - Reset mid-operation drops all in-flight state; the memory is reset by the same resetn.
- Credit rule: inst_req = resetn_q & ~br_e & (inflight + buf_count < BUF_DEPTH). resetn_q is resetn registered, so requests start the cycle after reset deasserts.
- Request acceptance (inst_req & inst_addr_ok):
  - fetch_pc pushed into the in-flight PC queue.
  - fetch_pc <= fetch_pc + 4, wrapping modulo 2^32.
  - inst_req/inst_addr are combinational from state and may drop without acceptance.
- Response (inst_data_ok):
  - cancel_cnt > 0: pop the in-flight queue, discard the data, decrement cancel_cnt.
  - Otherwise: pop the in-flight queue and push {pc, inst_rdata} into the buffer.
  - The credit rule guarantees the buffer is never full on a kept response. Overflow is a verification assertion.
- Output:
  - if_valid = (buf_count != 0) & ~br_e. if_pc/if_inst show the buffer head, or 0 when empty.
  - Head pops on if_valid & id_allowin.
  - Latency is 1 cycle from data_ok to if_valid. There is no bypass.
  - Push and pop in the same cycle are both honoured.
- Redirect (br_e=1):
  - fetch_pc <= {br_addr[31:2],2'b00}. Misalignment is not handled here.
  - Buffer flushed; head is not popped.
  - cancel_cnt <= cancel_cnt_eff + inflight_live. cancel_cnt_eff is cancel_cnt minus 1 if a cancelled response arrives this cycle. inflight_live is the non-cancelled in-flight count minus 1 if a live response arrives this cycle (that response is dropped).
  - No request is issued in the br_e cycle.
  - First new-path request is issued the next cycle.
- Back-to-back br_e: each cycle re-targets; the last br_addr wins. The cancel accounting stays exact.
- Counters:
  - inflight, buf_count and cancel_cnt are each clog2(BUF_DEPTH)+1 bits.
  - Invariant: cancel_cnt <= inflight <= BUF_DEPTH.
- inst_rdata is sampled only when inst_data_ok=1.

Test Plan:
1. Reset release, memory with 1-cycle addr_ok and next-cycle data_ok, id_allowin=1:
   - inst_addr sequence 0x80000000, 0x80000004, 0x80000008.
   - if_pc follows 1 cycle after each data_ok.
   - if_inst matches the memory image.
2. id_allowin=0 held, BUF_DEPTH=2:
   - Exactly 2 requests accepted, then inst_req=0.
   - Releasing id_allowin drains 0x80000000 then 0x80000004, and inst_req reasserts the cycle after the first pop.
3. Two requests outstanding (data latency 3), br_e=1 with br_addr=0x80001000:
   - Both late responses dropped.
   - Next accepted inst_addr=0x80001000.
   - First if_pc=0x80001000.
   - cancel_cnt returns to 0.
4. br_e in the same cycle as a live data_ok and a pending head:
   - if_valid=0 that cycle; no pop; response discarded.
   - Buffer empty next cycle; new fetch at br_addr.
5. br_e on consecutive cycles with targets 0x100 then 0x200:
   - Only 0x200 fetched; no stale instruction ever reaches if_valid.
6. fetch_pc=0xFFFFFFFC accepted: the next inst_addr is 0x00000000. Separately, resetn=0 while 2 requests are in flight clears all state, and the first post-reset inst_addr is RESET_PC.
